// File: rtl/btb_resolve_ctrl.sv
// btb_resolve_ctrl: buffers BTB lookups in order and turns resolved outcomes into BTB updates and redirects.
module btb_resolve_ctrl #(
    parameter int DEPTH = 4,
    parameter int IDXW  = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pred_valid,
    input  logic [31:0]     pred_pc,
    input  logic            pred_hit,
    input  logic            pred_taken,
    input  logic [31:0]     pred_target,
    input  logic [IDXW-1:0] pred_index,
    output logic            pred_ready,
    input  logic            res_valid,
    input  logic [31:0]     res_pc,
    input  logic            res_is_br,
    input  logic            res_is_call,
    input  logic            res_is_ret,
    input  logic            res_taken,
    input  logic [31:0]     res_target,
    output logic            res_ready,
    input  logic            flush,
    output logic            redirect,
    output logic [31:0]     redirect_pc,
    output logic            operate_en,
    output logic            add_entry,
    output logic            delete_entry,
    output logic            pre_error,
    output logic            pre_right,
    output logic            target_error,
    output logic            right_orien,
    output logic            push_ras,
    output logic            pop_ras,
    output logic [31:0]     operate_pc,
    output logic [IDXW-1:0] operate_index,
    output logic [31:0]     right_target
);
    localparam int AW = $clog2(DEPTH);
    typedef struct packed {
        logic [31:0]     pc;
        logic            hit;
        logic            taken;
        logic [31:0]     target;
        logic [IDXW-1:0] index;
    } entry_t;
    typedef struct packed {
        logic            redirect;
        logic [31:0]     redirect_pc;
        logic            op_en;
        logic            add;
        logic            del;
        logic            pe;
        logic            pr;
        logic            te;
        logic            orien;
        logic            push;
        logic            pop;
        logic [31:0]     op_pc;
        logic [IDXW-1:0] op_idx;
        logic [31:0]     rt;
    } out_t;
    entry_t fifo [DEPTH];
    entry_t head;
    logic [AW:0] wr_ptr, rd_ptr;
    logic full, empty, push, pop, mispred, hit, ptaken;
    out_t d, q;
    assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = wr_ptr == rd_ptr;
    assign pred_ready = !full;
    assign res_ready = !empty;
    assign head = fifo[rd_ptr[AW-1:0]];
    assign pop = res_valid && !empty && !flush;
    assign mispred = pop && d.redirect;
    assign push = pred_valid && !full && !flush && !mispred;
    // A head whose PC doesn't match the resolved instruction carries no usable prediction
    always_comb begin
        hit = (head.pc == res_pc) && head.hit;
        ptaken = (head.pc == res_pc) && head.taken;
        d = '0;
        d.add = !hit && res_is_br && res_taken;
        d.del = hit && !res_is_br;
        d.pe = hit && res_is_br && (ptaken != res_taken);
        d.te = hit && res_is_br && ptaken && res_taken && (head.target != res_target);
        d.pr = hit && res_is_br && !d.pe && !d.te;
        d.push = res_is_br && res_is_call && res_taken;
        d.pop = res_is_br && res_is_ret;
        d.redirect = d.add || (d.del && ptaken) || d.pe || d.te;
        d.redirect_pc = (d.add || d.te || (d.pe && res_taken)) ? res_target :
                        d.redirect ? res_pc + 32'd4 : 32'd0;
        d.op_en = d.add || d.del || d.pe || d.pr || d.te || d.push || d.pop;
        d.orien = d.op_en && res_taken;
        d.op_pc = d.op_en ? res_pc : 32'd0;
        d.op_idx = d.op_en ? head.index : '0;
        d.rt = d.op_en ? res_target : 32'd0;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            q <= '0;
        end else begin
            q <= pop ? d : '0;
            if (flush || mispred) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop) rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr[AW-1:0]] <= '{pred_pc, pred_hit, pred_taken, pred_target, pred_index};
    end
    assign redirect = q.redirect;
    assign redirect_pc = q.redirect_pc;
    assign operate_en = q.op_en;
    assign add_entry = q.add;
    assign delete_entry = q.del;
    assign pre_error = q.pe;
    assign pre_right = q.pr;
    assign target_error = q.te;
    assign right_orien = q.orien;
    assign push_ras = q.push;
    assign pop_ras = q.pop;
    assign operate_pc = q.op_pc;
    assign operate_index = q.op_idx;
    assign right_target = q.rt;
endmodule

// File: tb/tb_btb_resolve_ctrl.sv
// tb_btb_resolve_ctrl: directed vectors with a queued scoreboard checked by an output monitor.
module tb_btb_resolve_ctrl;
    logic clk = 0, reset = 1;
    logic pred_valid = 0, pred_hit = 0, pred_taken = 0;
    logic [31:0] pred_pc = 0, pred_target = 0;
    logic [4:0] pred_index = 0;
    logic pred_ready, res_ready;
    logic res_valid = 0, res_is_br = 0, res_is_call = 0, res_is_ret = 0, res_taken = 0, flush = 0;
    logic [31:0] res_pc = 0, res_target = 0;
    logic redirect, operate_en, add_entry, delete_entry, pre_error, pre_right, target_error;
    logic right_orien, push_ras, pop_ras;
    logic [31:0] redirect_pc, operate_pc, right_target;
    logic [4:0] operate_index;
    int compared = 0, mismatched = 0;

    typedef struct packed {
        logic        redir;
        logic [31:0] rpc;
        logic        op_en;
        logic [7:0]  s;
        logic [31:0] op_pc;
        logic [4:0]  idx;
        logic [31:0] rt;
    } exp_t;
    exp_t sb[$];

    btb_resolve_ctrl dut (
        .clk(clk), .reset(reset),
        .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_hit(pred_hit), .pred_taken(pred_taken),
        .pred_target(pred_target), .pred_index(pred_index), .pred_ready(pred_ready),
        .res_valid(res_valid), .res_pc(res_pc), .res_is_br(res_is_br), .res_is_call(res_is_call),
        .res_is_ret(res_is_ret), .res_taken(res_taken), .res_target(res_target), .res_ready(res_ready),
        .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc), .operate_en(operate_en),
        .add_entry(add_entry), .delete_entry(delete_entry), .pre_error(pre_error), .pre_right(pre_right),
        .target_error(target_error), .right_orien(right_orien), .push_ras(push_ras), .pop_ras(pop_ras),
        .operate_pc(operate_pc), .operate_index(operate_index), .right_target(right_target)
    );

    always #5 clk = ~clk;

    // s = {add, del, pre_error, pre_right, target_error, right_orien, push_ras, pop_ras}
    function automatic exp_t mk(logic r, logic [31:0] rpc, logic [7:0] s, logic [31:0] opc,
                                logic [4:0] idx, logic [31:0] rt);
        return '{r, rpc, |{s[7:3], s[1:0]}, s, opc, idx, rt};
    endfunction

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        compared++;
        if (a !== e) begin
            mismatched++;
            $display("FAIL %s got=%h want=%h", n, a, e);
        end
    endtask

    task automatic push(logic [31:0] pc, logic h, logic tk, logic [31:0] tgt, logic [4:0] idx);
        pred_valid = 1; pred_pc = pc; pred_hit = h; pred_taken = tk; pred_target = tgt; pred_index = idx;
        @(posedge clk); #1;
        pred_valid = 0;
    endtask

    task automatic set_res(logic [31:0] pc, logic br, logic call, logic ret, logic tk, logic [31:0] tgt);
        res_valid = 1; res_pc = pc; res_is_br = br; res_is_call = call; res_is_ret = ret;
        res_taken = tk; res_target = tgt;
    endtask

    task automatic resolve(logic [31:0] pc, logic br, logic call, logic ret, logic tk,
                           logic [31:0] tgt, logic has, exp_t e);
        set_res(pc, br, call, ret, tk, tgt);
        if (has) sb.push_back(e);
        @(posedge clk); #1;
        res_valid = 0;
    endtask

    always @(negedge clk) begin
        if (!reset && (operate_en || redirect)) begin
            exp_t a, e;
            a = '{redirect, redirect_pc, operate_en,
                  {add_entry, delete_entry, pre_error, pre_right, target_error, right_orien, push_ras, pop_ras},
                  operate_pc, operate_index, right_target};
            compared++;
            if (sb.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_output got=%h", a);
            end else begin
                e = sb.pop_front();
                if (a !== e) begin
                    mismatched++;
                    $display("FAIL update_bus got=%h want=%h", a, e);
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 0;
        chk("rst_pred_ready", 32'(pred_ready), 1);
        chk("rst_res_ready", 32'(res_ready), 0);
        chk("rst_outputs", {30'd0, operate_en, redirect}, 0);
        // miss, taken branch
        push(32'h1C000010, 0, 0, 0, 0);
        resolve(32'h1C000010, 1, 0, 0, 1, 32'h1C000100, 1,
                mk(1, 32'h1C000100, 8'b10000100, 32'h1C000010, 0, 32'h1C000100));
        chk("empty_after_miss", 32'(res_ready), 0);
        // direction mispredict with 3 queued
        push(32'h1C000020, 1, 1, 32'h1C000080, 7);
        push(32'h1C000024, 0, 0, 0, 0);
        push(32'h1C000028, 0, 0, 0, 0);
        chk("three_queued", 32'(res_ready), 1);
        resolve(32'h1C000020, 1, 0, 0, 0, 32'h1C000080, 1,
                mk(1, 32'h1C000024, 8'b00100000, 32'h1C000020, 7, 32'h1C000080));
        chk("mispredict_clears", 32'(res_ready), 0);
        // correct prediction decrements by one
        push(32'h1C000030, 1, 1, 32'h1C000100, 3);
        push(32'h1C000034, 0, 0, 0, 0);
        resolve(32'h1C000030, 1, 0, 0, 1, 32'h1C000100, 1,
                mk(0, 0, 8'b00010100, 32'h1C000030, 3, 32'h1C000100));
        chk("one_left", 32'(res_ready), 1);
        resolve(32'h1C000034, 0, 0, 0, 0, 0, 0, '0);
        chk("drained", 32'(res_ready), 0);
        // call then return with wrong RAS target
        push(32'h1C000200, 1, 1, 32'h1C000400, 9);
        resolve(32'h1C000200, 1, 1, 0, 1, 32'h1C000400, 1,
                mk(0, 0, 8'b00010110, 32'h1C000200, 9, 32'h1C000400));
        push(32'h1C000410, 1, 1, 32'h1C000204, 10);
        resolve(32'h1C000410, 1, 0, 1, 1, 32'h1C000300, 1,
                mk(1, 32'h1C000300, 8'b00001101, 32'h1C000410, 10, 32'h1C000300));
        // head mismatch is treated as a miss
        push(32'h1C000A00, 1, 1, 32'h1C000B00, 5);
        resolve(32'h1C000A40, 1, 0, 0, 1, 32'h1C000C00, 1,
                mk(1, 32'h1C000C00, 8'b10000100, 32'h1C000A40, 5, 32'h1C000C00));
        // full and stall
        for (int i = 0; i < 4; i++) push(32'h1C000500 + 32'(4 * i), 0, 0, 0, 0);
        chk("full", 32'(pred_ready), 0);
        push(32'h1C000510, 1, 1, 32'h1C000900, 1);
        pred_valid = 1; pred_pc = 32'h1C000520; pred_hit = 1; pred_taken = 1;
        set_res(32'h1C000500, 1, 0, 0, 0, 0);
        @(posedge clk); #1;
        pred_valid = 0; res_valid = 0;
        chk("pop_only_ready", 32'(pred_ready), 1);
        for (int i = 1; i < 4; i++) resolve(32'h1C000500 + 32'(4 * i), 1, 0, 0, 0, 0, 0, '0);
        chk("pushes_dropped", 32'(res_ready), 0);
        // flush with res_valid
        push(32'h1C000600, 1, 1, 32'h1C000700, 2);
        set_res(32'h1C000600, 1, 0, 0, 0, 0);
        flush = 1;
        @(posedge clk); #1;
        flush = 0; res_valid = 0;
        chk("flush_empty", 32'(res_ready), 0);
        // hit on non-branch, plus PC+4 wrap
        push(32'h1C000700, 1, 1, 32'h1C000800, 4);
        resolve(32'h1C000700, 0, 0, 0, 0, 0, 1, mk(1, 32'h1C000704, 8'b01000000, 32'h1C000700, 4, 0));
        push(32'hFFFFFFFC, 1, 1, 32'h00001000, 1);
        resolve(32'hFFFFFFFC, 0, 0, 0, 0, 0, 1, mk(1, 32'h0, 8'b01000000, 32'hFFFFFFFC, 1, 0));
        // reset wins over a same-cycle pop
        push(32'h1C000900, 1, 1, 32'h1C000A00, 6);
        set_res(32'h1C000900, 0, 0, 0, 0, 0);
        reset = 1;
        @(posedge clk); #1;
        reset = 0; res_valid = 0;
        chk("reset_res_ready", 32'(res_ready), 0);
        chk("reset_pred_ready", 32'(pred_ready), 1);
        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/btb_resolve_ctrl.md
Name: btb_resolve_ctrl

Overview:
- Update-side partner of the fetch-stage BTB.
- Buffers each BTB lookup result (one per fetched instruction) in an in-order prediction FIFO.
- Pairs each buffered prediction with the instruction's resolved outcome from ID, classifies the outcome, and drives the BTB update bus plus a frontend redirect.
- Sits between the IF-stage BTB lookup outputs and the ID-stage branch unit.

Parameters:
- DEPTH, 4, prediction FIFO entries; power of 2, at least 2.
- IDXW, 5, BTB entry index width; 32-entry BTB.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- pred_valid  in  1  BTB lookup result valid, one cycle after fetch
- pred_pc  in  32  fetch PC of that lookup
- pred_hit  in  1  BTB hit (ret_en)
- pred_taken  in  1  predicted direction
- pred_target  in  32  predicted target (BTB or RAS)
- pred_index  in  IDXW  hit entry index
- pred_ready  out  1  FIFO not full
- res_valid  in  1  resolved instruction from ID
- res_pc  in  32  its PC
- res_is_br  in  1  instruction is branch/jump
- res_is_call  in  1  bl / jirl-with-link call
- res_is_ret  in  1  jirl r0,r1,0 return
- res_taken  in  1  actual direction
- res_target  in  32  actual target
- res_ready  out  1  FIFO not empty
- flush  in  1  pipeline flush (exception/ertn)
- redirect  out  1  frontend redirect pulse
- redirect_pc  out  32  redirect address
- operate_en, add_entry, delete_entry, pre_error, pre_right, target_error, right_orien, push_ras, pop_ras  out  1 each  BTB update strobes
- operate_pc  out  32  update PC
- operate_index  out  IDXW  update entry index
- right_target  out  32  correct target

Behaviour:
- Reset: FIFO empty, pred_ready=1, res_ready=0, all outputs 0.
- Push on pred_valid&&pred_ready. Pop on res_valid&&res_ready. res_ready=0 stalls ID.
- Pointers are log2(DEPTH)+1 bits with wrap bit. pred_ready=!full, not relaxed by a same-cycle pop. Simultaneous push and pop when neither full nor empty: count unchanged.
- Head mismatch (res_pc != head.pc): head is still popped; prediction is treated as hit=0, taken=0.
- Classification, evaluated at pop, with hit/taken/target/index taken from the head:
  - A: !hit, br, taken → add_entry; redirect to res_target.
  - B: !hit, br, !taken → no BTB update; no redirect.
  - C: hit, !br → delete_entry; redirect to res_pc+4 only if pred_taken.
  - D: hit, br, pred_taken != res_taken → pre_error; redirect to res_taken ? res_target : res_pc+4.
  - E: hit, br, both taken, pred_target != res_target → target_error; redirect to res_target. For returns the BTB ignores the target write because pop_ras=1.
  - F: hit, br, otherwise → pre_right; no redirect.
  - G: !hit, !br → nothing.
- Update bus field values:
  - right_orien=res_taken.
  - right_target=res_target.
  - operate_pc=res_pc.
  - operate_index=head index.
- RAS strobes:
  - push_ras=res_is_call&&res_taken.
  - pop_ras=res_is_ret.
  - Both apply in every class with br=1.
- operate_en=OR of add/delete/pre_error/pre_right/target_error/push_ras/pop_ras.
- Timing: all outputs registered, valid exactly one cycle after the pop edge, single-cycle pulses. Non-asserted strobes are 0; data fields are 0 when operate_en=0.
- Misprediction (any redirect): at the pop edge the whole FIFO is cleared, because younger entries are wrong-path. A push in that same cycle is dropped.
- flush: highest priority. It clears the FIFO, suppresses any pop in that cycle (no outputs next cycle), and drops a same-cycle push. Registered outputs already launched from the previous cycle still appear.
- Address arithmetic: PC+4 is 32-bit wrap-around (0xFFFFFFFC+4=0).
- reset mid-operation: next cycle equals the post-reset state; pulses in flight are cancelled.

Test Plan:
- Miss, taken branch: push pc=0x1C000010, hit=0; resolve br, taken, target=0x1C000100 → next cycle add_entry=1, operate_pc=0x1C000010, right_target=0x1C000100, redirect_pc=0x1C000100.
- Direction mispredict with 3 queued entries: head hit, idx=7, pred_taken=1; resolve not-taken at pc=0x1C000020 → pre_error=1, right_orien=0, operate_index=7, redirect_pc=0x1C000024, res_ready=0 the next cycle.
- Correct prediction: hit, taken, target match → pre_right=1, redirect=0, FIFO count decremented by 1.
- Call/return: bl hit and correct → pre_right=1, push_ras=1. Later return hit with RAS target 0x1C000204 vs actual 0x1C000300 → target_error=1, pop_ras=1, redirect_pc=0x1C000300.
- Full/stall: 4 pushes → pred_ready=0, 5th pred_valid ignored. Then a pop and a push in the same cycle → only the pop takes effect. Empty FIFO → res_ready=0.
- flush on the same cycle as res_valid: no outputs next cycle, FIFO empty. Hit on a non-branch with pred_taken=1 → delete_entry=1, redirect_pc=pc+4.
